framebuffer_scanout: RTL and testbench

FRAMEBUFFER_SCANOUT -- requirements
Module: framebuffer_scanout

---
 rtl/rush3d_pkg.sv | 24 ++
 rtl/scanout_fifo.sv | 64 ++++++
 rtl/framebuffer_scanout.sv | 258 +++++++++++++++++++++++++
 tb/tb_framebuffer_scanout.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rush3d_pkg.sv
// rush3d_pkg -- shared types for the framebuffer scanout block.
//   scan_state_e   : fetch FSM states (IDLE / FETCH / DRAIN)
//   pix_fmt_e      : framebuffer pixel format (XRGB8888 or RGB565)
//   rgb565_to_888  : widens a 565 pixel to 888 by replicating each
//                    channel's MSBs into the new low bits, so full-scale
//                    565 maps to full-scale 888.
package rush3d_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_e;

    typedef enum logic {
        FMT_XRGB8888 = 1'b0,
        FMT_RGB565   = 1'b1
    } pix_fmt_e;

    function automatic logic [23:0] rgb565_to_888(input logic [15:0] c);
        return {c[15:11], c[15:13], c[10:5], c[10:9], c[4:0], c[4:2]};
    endfunction

endpackage

// File: rtl/scanout_fifo.sv
// scanout_fifo -- synchronous line-buffer FIFO with show-ahead output.
// Ports:
//   clock, reset  : clock, asynchronous active-high reset
//   flush         : synchronous empty; wins over push and pop
//   push, wdata   : write one word (ignored when full)
//   pop           : advance past the head word (ignored when empty)
//   rdata         : head word, valid whenever empty=0
//   empty         : no words stored
//   level         : words currently stored (0..DEPTH)
module scanout_fifo #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic        full, do_push, do_pop;

    assign level   = wptr_q - rptr_q;
    assign empty   = (wptr_q == rptr_q);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout -- fetches the front framebuffer over an Avalon-MM
// burst master into a line FIFO and unpacks it into one RGB888 pixel per
// display request.
// Ports:
//   clock, reset                     : sole clock, async active-high reset
//   address/burstcount/read          : Avalon burst request (held under waitrequest)
//   waitrequest/readdata/readdatavalid : Avalon slave response
//   buffer_sel/pixel_format/frame_words : frame parameters, sampled on frame_start
//   frame_start                      : vsync pulse; flushes and restarts the frame
//   pixel_ready                      : display takes a pixel this cycle
//   pixel/pixel_valid                : registered output pixel
//   underflow                        : sticky starvation flag, cleared on frame_start
//   active_buffer                    : buffer currently being scanned
module framebuffer_scanout
    import rush3d_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 29,
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    BURST_LEN   = 16,
    parameter int                    FIFO_DEPTH  = 256,
    parameter int                    NUM_BUFFERS = 4,
    parameter logic [ADDR_WIDTH-1:0] FB_BASE     = 29'h0C00_0000,
    parameter logic [ADDR_WIDTH-1:0] FB_STRIDE   = 29'h0010_0000
) (
    input  logic                           clock,
    input  logic                           reset,
    output logic [ADDR_WIDTH-1:0]          address,
    output logic [7:0]                     burstcount,
    output logic                           read,
    input  logic                           waitrequest,
    input  logic [DATA_WIDTH-1:0]          readdata,
    input  logic                           readdatavalid,
    input  logic [$clog2(NUM_BUFFERS)-1:0] buffer_sel,
    input  logic                           pixel_format,
    input  logic [23:0]                    frame_words,
    input  logic                           frame_start,
    input  logic                           pixel_ready,
    output logic [23:0]                    pixel,
    output logic                           pixel_valid,
    output logic                           underflow,
    output logic [$clog2(NUM_BUFFERS)-1:0] active_buffer
);
    localparam int BUF_W = $clog2(NUM_BUFFERS);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PPW32 = DATA_WIDTH / 32;
    localparam int PPW16 = DATA_WIDTH / 16;
    localparam int IDX_W = $clog2(PPW16);

    scan_state_e           state_q, state_d;
    logic [BUF_W-1:0]      buf_q, buf_d;
    pix_fmt_e              fmt_q, fmt_d;
    logic [23:0]           req_rem_q, req_rem_d;     // words not yet requested
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d; // start of the next burst
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            bc_q, bc_d;
    logic                  read_q, read_d;
    // Outstanding bursts (at most two), counted from issue so a request
    // still stalled by waitrequest already holds its FIFO reservation.
    logic [1:0]            nbursts_q, nbursts_d;
    logic [7:0]            head_left_q, head_left_d; // beats left in oldest burst
    logic [7:0]            tail_len_q, tail_len_d;   // length of the younger burst
    logic [8:0]            out_beats_q, out_beats_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [23:0]           pixel_q, pixel_d;
    logic                  pixel_valid_q, pixel_valid_d;
    logic                  underflow_q, underflow_d;

    logic                  accept, issue, room;
    logic [7:0]            bc_new;
    logic                  fifo_push, fifo_pop, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic [LVL_W-1:0]      fifo_level;
    logic [IDX_W-1:0]      last_idx;
    logic [23:0]           unpacked;

    function automatic logic [ADDR_WIDTH-1:0] buf_base(input logic [BUF_W-1:0] b);
        return FB_BASE + ADDR_WIDTH'(b) * FB_STRIDE;
    endfunction

    // Beats arriving in DRAIN, or alongside a frame_start, belong to the old
    // frame and never enter the FIFO.
    assign fifo_push = readdatavalid && (state_q == ST_FETCH) && !frame_start;

    scanout_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (frame_start),
        .push  (fifo_push),
        .wdata (readdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign accept = read_q && !waitrequest;
    assign bc_new = (req_rem_q < 24'(BURST_LEN)) ? req_rem_q[7:0] : 8'(BURST_LEN);
    // Free space minus reserved beats must hold a full burst.
    assign room   = (32'(fifo_level) + 32'(out_beats_q) + 32'(BURST_LEN)) <= 32'(FIFO_DEPTH);
    assign issue  = (state_q == ST_FETCH) && !frame_start && !read_q &&
                    (nbursts_q < 2'd2) && (req_rem_q != '0) && room;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start && frame_words != '0) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (frame_start) begin
                    if (nbursts_q != '0)          state_d = ST_DRAIN;
                    else if (frame_words == '0)   state_d = ST_IDLE;
                end else if (req_rem_q == '0 && nbursts_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (nbursts_q == '0) state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request side: frame parameters, burst issue and outstanding tracking.
    always_comb begin
        buf_d       = buf_q;
        fmt_d       = fmt_q;
        req_rem_d   = req_rem_q;
        next_addr_d = next_addr_q;
        addr_d      = addr_q;
        bc_d        = bc_q;
        read_d      = read_q;
        nbursts_d   = nbursts_q;
        head_left_d = head_left_q;
        tail_len_d  = tail_len_q;
        out_beats_d = out_beats_q;

        if (frame_start) begin
            buf_d       = buffer_sel;
            fmt_d       = pix_fmt_e'(pixel_format);
            req_rem_d   = frame_words;
            next_addr_d = buf_base(buffer_sel);
        end else if (issue) begin
            req_rem_d   = req_rem_q - 24'(bc_new);
            next_addr_d = next_addr_q + ADDR_WIDTH'(bc_new);
            addr_d      = next_addr_q;
            bc_d        = bc_new;
            read_d      = 1'b1;
        end

        if (accept) read_d = 1'b0;

        if (readdatavalid && nbursts_q != '0) begin
            out_beats_d = out_beats_q - 1'b1;
            if (head_left_q == 8'd1) begin
                nbursts_d   = nbursts_q - 1'b1;
                head_left_d = tail_len_q;
            end else begin
                head_left_d = head_left_q - 1'b1;
            end
        end

        if (issue) begin
            out_beats_d = out_beats_d + 9'(bc_new);
            if (nbursts_d == '0) head_left_d = bc_new;
            else                 tail_len_d  = bc_new;
            nbursts_d = nbursts_d + 1'b1;
        end
    end

    // Unpacker and registered pixel output.
    assign last_idx = (fmt_q == FMT_RGB565) ? IDX_W'(PPW16 - 1) : IDX_W'(PPW32 - 1);
    assign unpacked = (fmt_q == FMT_RGB565)
                    ? rgb565_to_888(16'(fifo_rdata >> {idx_q, 4'b0}))
                    : 24'(fifo_rdata >> {idx_q, 5'b0});

    always_comb begin
        pixel_d       = pixel_q;
        pixel_valid_d = pixel_valid_q;
        underflow_d   = underflow_q;
        idx_d         = idx_q;
        fifo_pop      = 1'b0;
        if (frame_start) begin
            idx_d       = '0;
            underflow_d = 1'b0;
            if (pixel_ready) begin
                pixel_d       = '0;
                pixel_valid_d = 1'b0;
            end
        end else if (pixel_ready) begin
            if (!fifo_empty) begin
                pixel_d       = unpacked;
                pixel_valid_d = 1'b1;
                if (idx_q == last_idx) begin
                    idx_d    = '0;
                    fifo_pop = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                pixel_d       = '0;
                pixel_valid_d = 1'b0;
                underflow_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            buf_q         <= '0;
            fmt_q         <= FMT_XRGB8888;
            req_rem_q     <= '0;
            next_addr_q   <= '0;
            addr_q        <= '0;
            bc_q          <= '0;
            read_q        <= 1'b0;
            nbursts_q     <= '0;
            head_left_q   <= '0;
            tail_len_q    <= '0;
            out_beats_q   <= '0;
            idx_q         <= '0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            fmt_q         <= fmt_d;
            req_rem_q     <= req_rem_d;
            next_addr_q   <= next_addr_d;
            addr_q        <= addr_d;
            bc_q          <= bc_d;
            read_q        <= read_d;
            nbursts_q     <= nbursts_d;
            head_left_q   <= head_left_d;
            tail_len_q    <= tail_len_d;
            out_beats_q   <= out_beats_d;
            idx_q         <= idx_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            underflow_q   <= underflow_d;
        end
    end

    assign address       = addr_q;
    assign burstcount    = bc_q;
    assign read          = read_q;
    assign pixel         = pixel_q;
    assign pixel_valid   = pixel_valid_q;
    assign underflow     = underflow_q;
    assign active_buffer = buf_q;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb_framebuffer_scanout -- directed self-checking bench for framebuffer_scanout
// with a behavioural Avalon burst slave (programmable waitrequest and latency).
`timescale 1ns/1ps
module tb_framebuffer_scanout;

    localparam logic [28:0] BASE   = 29'h0C00_0000;
    localparam logic [28:0] STRIDE = 29'h0010_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [28:0] address;
    logic [7:0]  burstcount;
    logic        read;
    logic        waitrequest = 1'b0;
    logic [63:0] readdata = '0;
    logic        readdatavalid = 1'b0;
    logic [1:0]  buffer_sel = '0;
    logic        pixel_format = 1'b0;
    logic [23:0] frame_words = '0;
    logic        frame_start = 1'b0;
    logic        pixel_ready = 1'b0;
    logic [23:0] pixel;
    logic        pixel_valid;
    logic        underflow;
    logic [1:0]  active_buffer;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    framebuffer_scanout dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .burstcount    (burstcount),
        .read          (read),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .buffer_sel    (buffer_sel),
        .pixel_format  (pixel_format),
        .frame_words   (frame_words),
        .frame_start   (frame_start),
        .pixel_ready   (pixel_ready),
        .pixel         (pixel),
        .pixel_valid   (pixel_valid),
        .underflow     (underflow),
        .active_buffer (active_buffer)
    );

    // ---------------- Avalon slave model ----------------
    typedef struct { logic [28:0] addr; int bc; int start; } pend_t;
    typedef struct { logic [28:0] addr; int bc; int dlv; } blog_t;
    pend_t pend[$];
    blog_t blog[$];
    int    cyc = 0, beat = 0, delivered = 0, lat = 0, mem_mode = 0;
    logic  wait_force = 1'b0;

    function automatic logic [63:0] mem_data(input logic [28:0] a);
        if (mem_mode == 1) return 64'h0000_07E0_001F_F800;
        return {8'hDD, 24'(a * 2 + 1), 8'hEE, 24'(a * 2)};
    endfunction

    // Expected XRGB pixel k (0 = low half) of the word at address a.
    function automatic logic [23:0] xp(input logic [28:0] a, input int k);
        return 24'(a * 2 + k);
    endfunction

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            pend.delete();
            beat = 0;
            readdatavalid = 1'b0;
            waitrequest = wait_force;
        end else begin
            if (pend.size() > 0 && cyc >= pend[0].start) begin
                readdata = mem_data(pend[0].addr + 29'(beat));
                readdatavalid = 1'b1;
                delivered++;
                beat++;
                if (beat == pend[0].bc) begin
                    void'(pend.pop_front());
                    beat = 0;
                end
            end else begin
                readdatavalid = 1'b0;
            end
            waitrequest = wait_force;
            if (read && !waitrequest) begin
                pend.push_back('{address, int'(burstcount), cyc + 1 + lat});
                blog.push_back('{address, int'(burstcount), delivered});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic start_frame(input logic [1:0] b, input logic f, input logic [23:0] w,
                               input logic rdy);
        buffer_sel = b; pixel_format = f; frame_words = w;
        frame_start = 1'b1; pixel_ready = rdy;
        @(negedge clock);
        frame_start = 1'b0; pixel_ready = 1'b0;
    endtask

    task automatic pull(output logic [23:0] p, output logic v);
        pixel_ready = 1'b1;
        @(negedge clock);
        pixel_ready = 1'b0;
        p = pixel; v = pixel_valid;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        tick(2);
        n_cmp++;
        if ({read, address, burstcount, pixel, pixel_valid, underflow, active_buffer} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rd=%b a=%h bc=%0d px=%h v=%b uf=%b ab=%0d want all 0",
                     read, address, burstcount, pixel, pixel_valid, underflow, active_buffer);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_xrgb;
        logic [23:0] p; logic v;
        blog.delete(); lat = 0; mem_mode = 0;
        start_frame(2'd0, 1'b0, 24'd40, 1'b0);
        tick(60);
        n_cmp++;
        if (blog.size() != 3) begin
            n_fail++; $display("FAIL xrgb_burst_count: got %0d want 3", blog.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (blog[i].addr !== 29'(BASE + 16 * i) || blog[i].bc != (i < 2 ? 16 : 8)) begin
                    n_fail++;
                    $display("FAIL xrgb_burst[%0d]: got a=%h bc=%0d want a=%h bc=%0d", i,
                             blog[i].addr, blog[i].bc, 29'(BASE + 16 * i), (i < 2 ? 16 : 8));
                end
            end
        end
        for (int i = 0; i < 80; i++) begin
            pull(p, v);
            n_cmp++;
            if (v !== 1'b1 || p !== xp(29'(BASE + i / 2), i % 2)) begin
                n_fail++;
                $display("FAIL xrgb_pix[%0d]: got %h v=%b want %h v=1", i, p, v,
                         xp(29'(BASE + i / 2), i % 2));
            end
        end
        n_cmp++;
        if (underflow !== 1'b0 || read !== 1'b0) begin
            n_fail++; $display("FAIL xrgb_end: got uf=%b rd=%b want 0 0", underflow, read);
        end
    endtask

    task automatic test_frame_start_ready;
        logic [23:0] p; logic v; int nb;
        nb = blog.size();
        start_frame(2'd2, 1'b0, 24'd0, 1'b1);
        n_cmp++;
        if (pixel !== 24'h0 || pixel_valid !== 1'b0 || underflow !== 1'b0 || active_buffer !== 2'd2) begin
            n_fail++;
            $display("FAIL fs_ready: got px=%h v=%b uf=%b ab=%0d want 0 0 0 2",
                     pixel, pixel_valid, underflow, active_buffer);
        end
        tick(10);
        n_cmp++;
        if (blog.size() != nb || read !== 1'b0) begin
            n_fail++; $display("FAIL zero_words_fetch: got bursts=%0d rd=%b want %0d 0", blog.size(), read, nb);
        end
        pull(p, v);
        n_cmp++;
        if (p !== 24'h0 || v !== 1'b0 || underflow !== 1'b1) begin
            n_fail++; $display("FAIL empty_underflow: got px=%h v=%b uf=%b want 0 0 1", p, v, underflow);
        end
    endtask

    task automatic test_rgb565;
        logic [23:0] p; logic v;
        logic [23:0] exp565 [4];
        exp565 = '{24'hFF0000, 24'h0000FF, 24'h00FF00, 24'h000000};
        blog.delete(); mem_mode = 1;
        start_frame(2'd0, 1'b1, 24'd1, 1'b0);
        tick(10);
        n_cmp++;
        if (blog.size() != 1 || blog[0].addr !== BASE || blog[0].bc != 1) begin
            n_fail++; $display("FAIL rgb565_burst: got n=%0d want one burst a=%h bc=1", blog.size(), BASE);
        end
        for (int i = 0; i < 4; i++) begin
            pull(p, v);
            n_cmp++;
            if (p !== exp565[i] || v !== 1'b1) begin
                n_fail++; $display("FAIL rgb565_pix[%0d]: got %h v=%b want %h v=1", i, p, v, exp565[i]);
            end
        end
        pull(p, v);
        n_cmp++;
        if (p !== 24'h0 || v !== 1'b0 || underflow !== 1'b1) begin
            n_fail++; $display("FAIL rgb565_over: got px=%h v=%b uf=%b want 0 0 1", p, v, underflow);
        end
        mem_mode = 0;
    endtask

    task automatic test_swap;
        logic [23:0] p; logic v;
        blog.delete();
        start_frame(2'd1, 1'b0, 24'd64, 1'b0);
        buffer_sel = 2'd3;
        tick(80);
        n_cmp++;
        if (active_buffer !== 2'd1) begin
            n_fail++; $display("FAIL swap_hold_ab: got %0d want 1", active_buffer);
        end
        n_cmp++;
        if (blog.size() != 4) begin
            n_fail++; $display("FAIL swap_bursts: got %0d want 4", blog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (blog[i].addr !== 29'(BASE + STRIDE + 16 * i)) begin
                    n_fail++;
                    $display("FAIL swap_addr[%0d]: got %h want %h", i, blog[i].addr, 29'(BASE + STRIDE + 16 * i));
                end
            end
        end
        pull(p, v);
        n_cmp++;
        if (p !== xp(29'(BASE + STRIDE), 0) || v !== 1'b1) begin
            n_fail++; $display("FAIL swap_pix_old: got %h v=%b want %h", p, v, xp(29'(BASE + STRIDE), 0));
        end
        start_frame(2'd3, 1'b0, 24'd16, 1'b0);
        tick(30);
        n_cmp++;
        if (active_buffer !== 2'd3 || blog.size() != 5 || blog[blog.size()-1].addr !== 29'(BASE + 3 * STRIDE)) begin
            n_fail++;
            $display("FAIL swap_new: got ab=%0d n=%0d a=%h want ab=3 n=5 a=%h", active_buffer,
                     blog.size(), blog[blog.size()-1].addr, 29'(BASE + 3 * STRIDE));
        end
        pull(p, v);
        n_cmp++;
        if (p !== xp(29'(BASE + 3 * STRIDE), 0) || v !== 1'b1) begin
            n_fail++; $display("FAIL swap_pix_new: got %h v=%b want %h", p, v, xp(29'(BASE + 3 * STRIDE), 0));
        end
    endtask

    task automatic test_stall;
        logic [23:0] p; logic v;
        blog.delete(); lat = 0;
        wait_force = 1'b1;
        start_frame(2'd0, 1'b0, 24'd16, 1'b0);
        tick(2);
        n_cmp++;
        if (read !== 1'b1 || address !== BASE || burstcount !== 8'd16) begin
            n_fail++; $display("FAIL stall_req: got rd=%b a=%h bc=%0d want 1 %h 16", read, address, burstcount, BASE);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            n_cmp++;
            if (read !== 1'b1 || address !== BASE || burstcount !== 8'd16) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got rd=%b a=%h bc=%0d want 1 %h 16", i, read, address, burstcount, BASE);
            end
        end
        wait_force = 1'b0;
        tick(30);
        n_cmp++;
        if (blog.size() != 1) begin
            n_fail++; $display("FAIL stall_accept: got %0d bursts want 1", blog.size());
        end
        lat = 50;
        start_frame(2'd0, 1'b0, 24'd16, 1'b0);
        tick(5);
        pull(p, v);
        n_cmp++;
        if (p !== 24'h0 || v !== 1'b0 || underflow !== 1'b1) begin
            n_fail++; $display("FAIL latency_underflow: got px=%h v=%b uf=%b want 0 0 1", p, v, underflow);
        end
        tick(70);
        pull(p, v);
        n_cmp++;
        if (p !== xp(BASE, 0) || v !== 1'b1 || underflow !== 1'b1) begin
            n_fail++; $display("FAIL latency_sticky: got px=%h v=%b uf=%b want %h 1 1", p, v, underflow, xp(BASE, 0));
        end
        lat = 0;
    endtask

    task automatic test_drain;
        logic [23:0] p; logic v; int d0;
        logic [28:0] b2;
        b2 = 29'(BASE + 2 * STRIDE);
        blog.delete(); lat = 20;
        start_frame(2'd0, 1'b0, 24'd64, 1'b0);
        pull(p, v);
        tick(6);
        n_cmp++;
        if (underflow !== 1'b1 || blog.size() != 2) begin
            n_fail++; $display("FAIL drain_pre: got uf=%b bursts=%0d want 1 2", underflow, blog.size());
        end
        d0 = delivered;
        start_frame(2'd2, 1'b0, 24'd16, 1'b0);
        n_cmp++;
        if (underflow !== 1'b0 || active_buffer !== 2'd2) begin
            n_fail++; $display("FAIL drain_clear: got uf=%b ab=%0d want 0 2", underflow, active_buffer);
        end
        tick(100);
        n_cmp++;
        if (blog.size() != 3) begin
            n_fail++; $display("FAIL drain_bursts: got %0d want 3", blog.size());
        end else begin
            n_cmp++;
            if (blog[2].addr !== b2 || blog[2].bc != 16 || blog[2].dlv - d0 != 32) begin
                n_fail++;
                $display("FAIL drain_newburst: got a=%h bc=%0d discarded=%0d want a=%h bc=16 discarded=32",
                         blog[2].addr, blog[2].bc, blog[2].dlv - d0, b2);
            end
        end
        for (int i = 0; i < 32; i++) begin
            pull(p, v);
            n_cmp++;
            if (v !== 1'b1 || p !== xp(29'(b2 + i / 2), i % 2)) begin
                n_fail++;
                $display("FAIL drain_pix[%0d]: got %h v=%b want %h v=1", i, p, v, xp(29'(b2 + i / 2), i % 2));
            end
        end
        pull(p, v);
        n_cmp++;
        if (v !== 1'b0) begin
            n_fail++; $display("FAIL drain_leak: got v=%b px=%h want v=0", v, p);
        end
        lat = 0;
    endtask

    task automatic test_reset_mid;
        logic [23:0] p; logic v;
        blog.delete(); lat = 5; wait_force = 1'b1;
        start_frame(2'd1, 1'b0, 24'd64, 1'b0);
        tick(3);
        n_cmp++;
        if (read !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_pre: got rd=%b want 1", read);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({read, address, burstcount, pixel, pixel_valid, underflow, active_buffer} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got rd=%b a=%h bc=%0d px=%h v=%b uf=%b ab=%0d want all 0",
                     read, address, burstcount, pixel, pixel_valid, underflow, active_buffer);
        end
        @(negedge clock);
        wait_force = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(3);
        n_cmp++;
        if (read !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_idle: got rd=%b want 0", read);
        end
        blog.delete();
        start_frame(2'd0, 1'b0, 24'd16, 1'b0);
        tick(40);
        n_cmp++;
        if (blog.size() != 1 || blog[0].addr !== BASE || blog[0].bc != 16) begin
            n_fail++; $display("FAIL rst_restart_burst: got n=%0d want one burst at %h bc=16", blog.size(), BASE);
        end
        pull(p, v);
        n_cmp++;
        if (p !== xp(BASE, 0) || v !== 1'b1) begin
            n_fail++; $display("FAIL rst_restart_pix: got %h v=%b want %h v=1", p, v, xp(BASE, 0));
        end
        lat = 0;
    endtask

    initial begin
        test_reset();
        test_xrgb();
        test_frame_start_ready();
        test_rgb565();
        test_swap();
        test_stall();
        test_drain();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
